// File: rtl/adc_sample_scheduler_if.sv
// rtl/adc_sample_scheduler_if.sv - command/response bus between the sample scheduler and the I2C byte master
//
// Purpose: groups the byte-level I2C master handshake into one bundle.
// Signals:
//   m_cmd_valid  scheduler -> master  command valid
//   m_cmd_ready  master -> scheduler  command accepted this cycle
//   m_cmd[2:0]   scheduler -> master  1=START 2=WRITE 3=READ_ACK 4=READ_NACK 5=STOP
//   m_wdata[7:0] scheduler -> master  byte for WRITE
//   m_done       master -> scheduler  pulse: accepted command finished on the bus
//   m_rdata[7:0] master -> scheduler  read byte, valid with m_done
//   m_nack       master -> scheduler  slave NACKed the WRITE, valid with m_done
// Modports: master = scheduler side (issues commands), slave = I2C byte master side.
interface adc_sample_scheduler_if;
  logic       m_cmd_valid;
  logic       m_cmd_ready;
  logic [2:0] m_cmd;
  logic [7:0] m_wdata;
  logic       m_done;
  logic [7:0] m_rdata;
  logic       m_nack;

  modport master (
    output m_cmd_valid, m_cmd, m_wdata,
    input  m_cmd_ready, m_done, m_rdata, m_nack
  );

  modport slave (
    input  m_cmd_valid, m_cmd, m_wdata,
    output m_cmd_ready, m_done, m_rdata, m_nack
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - periodic round-robin ADC conversion sequencer over an I2C byte master
//
// Purpose: a programmable timer triggers a conversion; the next enabled channel is
// picked round-robin, its config byte is written to the ADC and the 12-bit result
// read back through the I2C byte master command handshake.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        run the sample timer
//   period        tick every period+1 cycles
//   ch_mask       enabled channels, bit n = channel n
//   clr_err       clears the sticky overrun/err_nack flags
//   bus           I2C byte master command bus (master modport)
//   sample_valid  one-cycle pulse with sample_data/sample_ch
//   sample_data   12-bit conversion result, held until the next sample
//   sample_ch     channel of sample_data
//   busy          conversion sequence in progress
//   overrun       sticky: tick arrived while a sequence was running
//   err_nack      sticky: a WRITE was NACKed
module adc_sample_scheduler #(
  parameter logic [6:0] DEV_ADDR = 7'h28,
  parameter int         PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          ch_mask,
  input  logic                clr_err,
  adc_sample_scheduler_if.master bus,
  output logic                sample_valid,
  output logic [11:0]         sample_data,
  output logic [1:0]          sample_ch,
  output logic                busy,
  output logic                overrun,
  output logic                err_nack
);

  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_WRITE     = 3'd2;
  localparam logic [2:0] CMD_READ_ACK  = 3'd3;
  localparam logic [2:0] CMD_READ_NACK = 3'd4;
  localparam logic [2:0] CMD_STOP      = 3'd5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, EMIT} state_t;

  state_t              state, state_n;
  logic [3:0]          step, step_n;
  logic                abort, abort_n;   // sequence is finishing its STOP after a NACK
  logic [PERIOD_W-1:0] cnt;
  logic [1:0]          cur_ch;           // also the "last channel" for the round-robin
  logic [11:0]         result;
  logic                tick;
  logic [2:0]          cmd_c;
  logic [7:0]          wdata_c;
  logic                is_write;
  logic                start_seq;
  logic                done_ev;

  // Next set bit strictly after last, wrapping; offset 4 is last itself.
  function automatic logic [1:0] pick_next(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] c;
    pick_next = last;
    for (int i = 4; i >= 1; i--) begin
      c = last + 2'(i);
      if (mask[c]) pick_next = c;
    end
  endfunction

  assign tick      = enable && (cnt == '0);
  assign start_seq = (state == IDLE) && tick && (ch_mask != 4'd0);
  assign done_ev   = (state == WAIT_DONE) && bus.m_done;
  assign busy      = (state != IDLE);

  always_comb begin
    cmd_c    = 3'd0;
    wdata_c  = 8'h00;
    is_write = 1'b0;
    case (step)
      4'd0, 4'd4: cmd_c = CMD_START;
      4'd1: begin cmd_c = CMD_WRITE; wdata_c = {DEV_ADDR, 1'b0}; is_write = 1'b1; end
      4'd2: begin cmd_c = CMD_WRITE; wdata_c = 8'h10 << cur_ch; is_write = 1'b1; end
      4'd3, 4'd8: cmd_c = CMD_STOP;
      4'd5: begin cmd_c = CMD_WRITE; wdata_c = {DEV_ADDR, 1'b1}; is_write = 1'b1; end
      4'd6: cmd_c = CMD_READ_ACK;
      4'd7: cmd_c = CMD_READ_NACK;
      default: cmd_c = 3'd0;
    endcase
  end

  always_comb begin
    state_n         = state;
    step_n          = step;
    abort_n         = abort;
    bus.m_cmd_valid = 1'b0;
    bus.m_cmd       = 3'd0;
    bus.m_wdata     = 8'h00;
    sample_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (start_seq) begin
          state_n = ISSUE;
          step_n  = 4'd0;
          abort_n = 1'b0;
        end
      end
      ISSUE: begin
        bus.m_cmd_valid = 1'b1;
        bus.m_cmd       = cmd_c;
        bus.m_wdata     = wdata_c;
        if (bus.m_cmd_ready) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.m_done) begin
          if (step == 4'd8) begin
            state_n = abort ? IDLE : EMIT;
          end else if (is_write && bus.m_nack) begin
            step_n  = 4'd8;
            abort_n = 1'b1;
            state_n = ISSUE;
          end else begin
            step_n  = step + 4'd1;
            state_n = ISSUE;
          end
        end
      end
      EMIT: begin
        sample_valid = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      step        <= 4'd0;
      abort       <= 1'b0;
      cnt         <= '0;
      cur_ch      <= 2'd3;
      result      <= 12'd0;
      sample_data <= 12'd0;
      sample_ch   <= 2'd0;
      overrun     <= 1'b0;
      err_nack    <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      abort <= abort_n;

      if (!enable)         cnt <= '0;
      else if (cnt == '0)  cnt <= period;
      else                 cnt <= cnt - 1'b1;

      if (start_seq) cur_ch <= pick_next(cur_ch, ch_mask);

      if (done_ev) begin
        if (step == 4'd6) result[11:8] <= bus.m_rdata[3:0];
        if (step == 4'd7) result[7:0]  <= bus.m_rdata;
        if (step == 4'd8 && !abort) begin
          sample_data <= result;
          sample_ch   <= cur_ch;
        end
      end

      // Set has priority over clear.
      if (tick && state != IDLE) overrun <= 1'b1;
      else if (clr_err)          overrun <= 1'b0;

      if (done_ev && is_write && bus.m_nack && step != 4'd8) err_nack <= 1'b1;
      else if (clr_err)                                       err_nack <= 1'b0;
    end
  end

endmodule
